trng_pool_ctrl: RTL and testbench

Fill controller for the TRNG entropy pool. It takes raw entropy bits one at a time and packs them into bytes. Each completed byte is written into one lane of the downstream byte-write pool register through a one-hot byte-write-enable. When the pool is full it presents it to the consumer over a valid/ready handshake. It also runs a repetition-count health test and latches a sticky error if the source sticks.

---
 rtl/trng_pool_ctrl.sv | 149 ++++++++++++++
 tb/tb_trng_pool_ctrl.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trng_pool_ctrl.sv
// trng_pool_ctrl: packs raw entropy bits into bytes, writes each byte into one
// lane of the downstream pool register, presents the full pool over
// valid/ready and runs a repetition-count health test with a sticky error.
module trng_pool_ctrl #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned BYTE_WIDTH = 8,
  parameter int unsigned WE_WIDTH   = (WIDTH - 1) / BYTE_WIDTH + 1,
  parameter int unsigned REP_LIMIT  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en_i,
  input  logic                bit_valid_i,
  input  logic                bit_i,
  output logic                bit_ready_o,
  output logic [WE_WIDTH-1:0] we_o,
  output logic [WIDTH-1:0]    wdata_o,
  output logic                pool_valid_o,
  input  logic                pool_ready_i,
  output logic                err_o
);

  localparam int unsigned CNT_W  = (BYTE_WIDTH > 1) ? $clog2(BYTE_WIDTH) : 1;
  localparam int unsigned LANE_W = (WE_WIDTH > 1) ? $clog2(WE_WIDTH) : 1;
  localparam int unsigned REP_W  = $clog2(REP_LIMIT + 1);

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(BYTE_WIDTH - 1);
  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(WE_WIDTH - 1);
  localparam logic [REP_W-1:0]  REP_MAX   = REP_W'(REP_LIMIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_WAIT,
    S_FULL,
    S_ERROR
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic [LANE_W-1:0]     r_lane;
  logic [BYTE_WIDTH-1:0] r_shift;
  logic [REP_W-1:0]      r_rep_cnt;
  logic                  r_prev_bit;
  logic [WE_WIDTH-1:0]   r_we;
  logic [WIDTH-1:0]      r_wdata;

  logic                  w_abort;
  logic                  w_accept;
  logic                  w_byte_done;
  logic                  w_trip;
  logic                  w_lane_wr;
  logic [REP_W-1:0]      w_rep_nxt;
  logic [BYTE_WIDTH-1:0] w_byte;
  logic [WIDTH-1:0]      w_wdata_rep;

  // Handshake decode is a pure function of state.
  assign bit_ready_o  = (r_state == S_FILL);
  assign pool_valid_o = (r_state == S_FULL);
  assign err_o        = (r_state == S_ERROR);
  assign we_o         = r_we;
  assign wdata_o      = r_wdata;

  // Accept / byte-complete / health-trip decode; dropping en_i in FILL
  // discards the offered bit so an abort never produces a lane write.
  always_comb begin
    w_abort     = (r_state == S_FILL) && !en_i;
    w_accept    = bit_valid_i && bit_ready_o && !w_abort;
    w_byte      = BYTE_WIDTH'({r_shift, bit_i});
    w_wdata_rep = WIDTH'({WE_WIDTH{w_byte}});
    w_rep_nxt   = REP_W'(1);
    if ((r_rep_cnt != '0) && (bit_i == r_prev_bit)) begin
      w_rep_nxt = r_rep_cnt + 1'b1;
    end
    w_byte_done = w_accept && (r_bit_cnt == CNT_LAST);
    w_trip      = w_accept && (w_rep_nxt == REP_MAX);
    w_lane_wr   = w_byte_done && !w_trip;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (en_i) w_state_nxt = S_FILL;
      S_FILL: begin
        if (w_abort) begin
          w_state_nxt = S_IDLE;
        end else if (w_trip) begin
          w_state_nxt = S_ERROR;
        end else if (w_lane_wr && (r_lane == LANE_LAST)) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT:  w_state_nxt = S_FULL;
      S_FULL: begin
        if (pool_ready_i) begin
          w_state_nxt = en_i ? S_FILL : S_IDLE;
        end
      end
      S_ERROR: w_state_nxt = S_ERROR;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Packing datapath: shifter, counters, health state and lane-write pulse.
  // Every entry into IDLE clears collection state, covering both the FILL
  // abort and a pool consumed while en_i is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit_cnt  <= '0;
      r_lane     <= '0;
      r_shift    <= '0;
      r_rep_cnt  <= '0;
      r_prev_bit <= 1'b0;
      r_we       <= '0;
      r_wdata    <= '0;
    end else begin
      r_we <= '0;
      if (w_state_nxt == S_IDLE) begin
        r_bit_cnt  <= '0;
        r_lane     <= '0;
        r_shift    <= '0;
        r_rep_cnt  <= '0;
        r_prev_bit <= 1'b0;
      end else if (w_accept) begin
        r_shift    <= w_byte;
        r_prev_bit <= bit_i;
        r_rep_cnt  <= w_rep_nxt;
        r_bit_cnt  <= w_byte_done ? '0 : r_bit_cnt + 1'b1;
        if (w_lane_wr) begin
          r_we    <= WE_WIDTH'(1) << r_lane;
          r_wdata <= w_wdata_rep;
          r_lane  <= (r_lane == LANE_LAST) ? '0 : r_lane + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_trng_pool_ctrl.sv
// Directed bench for trng_pool_ctrl (WIDTH=32, 8-bit lanes, REP_LIMIT=16).
module tb_trng_pool_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en_i = 1'b0;
  logic        bit_valid_i = 1'b0;
  logic        bit_i = 1'b0;
  logic        bit_ready_o;
  logic [3:0]  we_o;
  logic [31:0] wdata_o;
  logic        pool_valid_o;
  logic        pool_ready_i = 1'b0;
  logic        err_o;

  int vec   = 0;
  int fails = 0;
  int cyc   = 0;

  // Downstream pool register and a log of every lane-write pulse.
  logic [31:0] pool_q = '0;
  logic [3:0]  lg_we[$];
  logic [31:0] lg_data[$];
  int          lg_cyc[$];

  trng_pool_ctrl #(
    .WIDTH(32),
    .BYTE_WIDTH(8),
    .REP_LIMIT(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en_i(en_i),
    .bit_valid_i(bit_valid_i),
    .bit_i(bit_i),
    .bit_ready_o(bit_ready_o),
    .we_o(we_o),
    .wdata_o(wdata_o),
    .pool_valid_o(pool_valid_o),
    .pool_ready_i(pool_ready_i),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    if (we_o != 4'b0000) begin
      lg_we.push_back(we_o);
      lg_data.push_back(wdata_o);
      lg_cyc.push_back(cyc);
      for (int l = 0; l < 4; l++) begin
        if (we_o[l]) pool_q[l*8 +: 8] = wdata_o[l*8 +: 8];
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // Offer one bit until accepted; optionally idle bit_valid_i for one cycle after.
  task automatic send_bit(input logic b, input bit gap);
    int n = 0;
    bit_valid_i = 1'b1;
    bit_i = b;
    while (bit_ready_o !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      vec++; fails++;
      $display("FAIL send_bit_timeout: got bit_ready_o=%b, required 1 within 100 cycles", bit_ready_o);
    end
    @(posedge clk); #1;
    bit_valid_i = 1'b0;
    if (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    for (int i = 7; i >= 0; i--) send_bit(b[i], gap);
  endtask

  task automatic consume();
    pool_ready_i = 1'b1;
    @(posedge clk); #1;
    pool_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vec++;
    if ({we_o, wdata_o, bit_ready_o, pool_valid_o, err_o} !== '0) begin
      fails++;
      $display("FAIL reset_in: got we=%b wdata=%h rdy=%b pv=%b err=%b, required all 0",
               we_o, wdata_o, bit_ready_o, pool_valid_o, err_o);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    vec++;
    if ({we_o, wdata_o, bit_ready_o, pool_valid_o, err_o} !== '0) begin
      fails++;
      $display("FAIL reset_idle: got we=%b wdata=%h rdy=%b pv=%b err=%b, required all 0",
               we_o, wdata_o, bit_ready_o, pool_valid_o, err_o);
    end
  endtask

  task automatic test_byte_order();
    logic [7:0] b[4] = '{8'hA5, 8'h3C, 8'h96, 8'h0F};
    logic [3:0] ew;
    int p0 = lg_we.size();
    en_i = 1'b1;
    for (int i = 0; i < 4; i++) send_byte(b[i], 1'b0);
    vec++;
    if (we_o !== 4'b1000 || pool_valid_o !== 1'b0 || bit_ready_o !== 1'b0) begin
      fails++;
      $display("FAIL order_wait: got we=%b pv=%b rdy=%b, required we=1000 pv=0 rdy=0",
               we_o, pool_valid_o, bit_ready_o);
    end
    @(posedge clk); #1;
    vec++;
    if (pool_valid_o !== 1'b1 || we_o !== 4'b0000 || wdata_o !== 32'h0F0F0F0F) begin
      fails++;
      $display("FAIL order_full: got pv=%b we=%b wdata=%h, required pv=1 we=0000 wdata=0f0f0f0f",
               pool_valid_o, we_o, wdata_o);
    end
    for (int i = 0; i < 4; i++) begin
      ew = 4'b0001 << i;
      vec++;
      if (lg_we.size() <= p0 + i || lg_we[p0+i] !== ew || lg_data[p0+i] !== {4{b[i]}} ||
          (i > 0 && lg_cyc[p0+i] - lg_cyc[p0+i-1] != 8)) begin
        fails++;
        $display("FAIL order_lane%0d: got we=%b data=%h, required we=%b data=%h every 8 cycles",
                 i, lg_we[p0+i], lg_data[p0+i], ew, {4{b[i]}});
      end
    end
    vec++;
    if (pool_q !== 32'h0F963CA5) begin
      fails++;
      $display("FAIL order_pool: got %h, required 0f963ca5", pool_q);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] b[4] = '{8'h12, 8'h34, 8'h56, 8'h78};
    logic [3:0] ew;
    int bad = 0;
    int p0 = lg_we.size();
    bit_valid_i = 1'b1;
    bit_i = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (bit_ready_o !== 1'b0 || pool_valid_o !== 1'b1 || we_o !== 4'b0000) bad++;
    end
    vec++;
    if (bad != 0 || lg_we.size() != p0) begin
      fails++;
      $display("FAIL bp_hold: got %0d bad cycles and %0d pulses, required 0 and 0", bad, lg_we.size() - p0);
    end
    bit_valid_i = 1'b0;
    consume();
    vec++;
    if (pool_valid_o !== 1'b0 || bit_ready_o !== 1'b1) begin
      fails++;
      $display("FAIL bp_release: got pv=%b rdy=%b, required pv=0 rdy=1", pool_valid_o, bit_ready_o);
    end
    for (int i = 0; i < 4; i++) send_byte(b[i], 1'b0);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      ew = 4'b0001 << i;
      vec++;
      if (lg_we.size() <= p0 + i || lg_we[p0+i] !== ew || lg_data[p0+i] !== {4{b[i]}}) begin
        fails++;
        $display("FAIL bp_lane%0d: got we=%b data=%h, required we=%b data=%h",
                 i, lg_we[p0+i], lg_data[p0+i], ew, {4{b[i]}});
      end
    end
    vec++;
    if (pool_q !== 32'h78563412 || pool_valid_o !== 1'b1) begin
      fails++;
      $display("FAIL bp_pool: got %h pv=%b, required 78563412 pv=1", pool_q, pool_valid_o);
    end
  endtask

  task automatic test_gaps();
    logic [7:0] b[4] = '{8'hC3, 8'h81, 8'hE7, 8'h24};
    logic [3:0] ew;
    int p0;
    consume();
    p0 = lg_we.size();
    for (int i = 0; i < 4; i++) send_byte(b[i], 1'b1);
    for (int i = 0; i < 4; i++) begin
      ew = 4'b0001 << i;
      vec++;
      if (lg_we.size() <= p0 + i || lg_we[p0+i] !== ew || lg_data[p0+i] !== {4{b[i]}} ||
          (i > 0 && lg_cyc[p0+i] - lg_cyc[p0+i-1] != 16)) begin
        fails++;
        $display("FAIL gap_lane%0d: got we=%b data=%h, required we=%b data=%h every 16 cycles",
                 i, lg_we[p0+i], lg_data[p0+i], ew, {4{b[i]}});
      end
    end
    vec++;
    if (pool_q !== 32'h24E781C3 || pool_valid_o !== 1'b1) begin
      fails++;
      $display("FAIL gap_pool: got %h pv=%b, required 24e781c3 pv=1", pool_q, pool_valid_o);
    end
  endtask

  task automatic test_abort();
    logic [7:0] b[4] = '{8'h11, 8'h22, 8'h44, 8'h88};
    logic [7:0] partial = 8'h6D;
    logic [3:0] ew;
    int p0, p1;
    consume();
    p0 = lg_we.size();
    send_byte(8'h9B, 1'b0);
    for (int i = 7; i >= 3; i--) send_bit(partial[i], 1'b0);
    en_i = 1'b0;
    bit_valid_i = 1'b1;
    bit_i = 1'b0;
    @(posedge clk); #1;
    vec++;
    if (bit_ready_o !== 1'b0 || we_o !== 4'b0000 || pool_valid_o !== 1'b0) begin
      fails++;
      $display("FAIL abort_idle: got rdy=%b we=%b pv=%b, required rdy=0 we=0000 pv=0",
               bit_ready_o, we_o, pool_valid_o);
    end
    bit_valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vec++;
    if (lg_we.size() != p0 + 1 || bit_ready_o !== 1'b0) begin
      fails++;
      $display("FAIL abort_pulses: got %0d pulses rdy=%b, required 1 pulse rdy=0", lg_we.size() - p0, bit_ready_o);
    end
    en_i = 1'b1;
    p1 = lg_we.size();
    for (int i = 0; i < 4; i++) send_byte(b[i], 1'b0);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      ew = 4'b0001 << i;
      vec++;
      if (lg_we.size() <= p1 + i || lg_we[p1+i] !== ew || lg_data[p1+i] !== {4{b[i]}}) begin
        fails++;
        $display("FAIL abort_lane%0d: got we=%b data=%h, required we=%b data=%h",
                 i, lg_we[p1+i], lg_data[p1+i], ew, {4{b[i]}});
      end
    end
    vec++;
    if (pool_q !== 32'h88442211 || pool_valid_o !== 1'b1) begin
      fails++;
      $display("FAIL abort_pool: got %h pv=%b, required 88442211 pv=1", pool_q, pool_valid_o);
    end
  endtask

  task automatic test_reset_states();
    logic [7:0] b = 8'h5A;
    // Reset while FULL.
    rst = 1'b1;
    @(posedge clk); #1;
    vec++;
    if ({we_o, wdata_o, bit_ready_o, pool_valid_o, err_o} !== '0) begin
      fails++;
      $display("FAIL rst_full: got we=%b wdata=%h rdy=%b pv=%b err=%b, required all 0",
               we_o, wdata_o, bit_ready_o, pool_valid_o, err_o);
    end
    rst = 1'b0;
    en_i = 1'b0;
    @(posedge clk); #1;
    vec++;
    if (bit_ready_o !== 1'b0 || pool_valid_o !== 1'b0) begin
      fails++;
      $display("FAIL rst_full_idle: got rdy=%b pv=%b, required 0 0", bit_ready_o, pool_valid_o);
    end
    // Reset while WAIT.
    en_i = 1'b1;
    for (int i = 0; i < 4; i++) send_byte(b, 1'b0);
    vec++;
    if (we_o !== 4'b1000 || pool_valid_o !== 1'b0) begin
      fails++;
      $display("FAIL rst_wait_pre: got we=%b pv=%b, required we=1000 pv=0", we_o, pool_valid_o);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    vec++;
    if ({we_o, wdata_o, bit_ready_o, pool_valid_o, err_o} !== '0) begin
      fails++;
      $display("FAIL rst_wait: got we=%b wdata=%h rdy=%b pv=%b err=%b, required all 0",
               we_o, wdata_o, bit_ready_o, pool_valid_o, err_o);
    end
    rst = 1'b0;
    en_i = 1'b0;
    @(posedge clk); #1;
    vec++;
    if (bit_ready_o !== 1'b0 || pool_valid_o !== 1'b0) begin
      fails++;
      $display("FAIL rst_wait_idle: got rdy=%b pv=%b, required 0 0", bit_ready_o, pool_valid_o);
    end
  endtask

  task automatic test_health();
    int p0;
    int bad = 0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    en_i = 1'b1;
    p0 = lg_we.size();
    for (int i = 0; i < 8; i++) send_bit(1'b1, 1'b0);
    vec++;
    if (we_o !== 4'b0001 || wdata_o !== 32'hFFFFFFFF || err_o !== 1'b0) begin
      fails++;
      $display("FAIL health_byte8: got we=%b wdata=%h err=%b, required 0001 ffffffff 0", we_o, wdata_o, err_o);
    end
    for (int i = 0; i < 7; i++) send_bit(1'b1, 1'b0);
    vec++;
    if (err_o !== 1'b0 || bit_ready_o !== 1'b1) begin
      fails++;
      $display("FAIL health_bit15: got err=%b rdy=%b, required err=0 rdy=1", err_o, bit_ready_o);
    end
    send_bit(1'b1, 1'b0);
    vec++;
    if (err_o !== 1'b1 || we_o !== 4'b0000 || bit_ready_o !== 1'b0 || lg_we.size() != p0 + 1) begin
      fails++;
      $display("FAIL health_trip: got err=%b we=%b rdy=%b pulses=%0d, required err=1 we=0000 rdy=0 pulses=1",
               err_o, we_o, bit_ready_o, lg_we.size() - p0);
    end
    bit_valid_i = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (err_o !== 1'b1 || bit_ready_o !== 1'b0 || pool_valid_o !== 1'b0 || we_o !== 4'b0000) bad++;
    end
    bit_valid_i = 1'b0;
    vec++;
    if (bad != 0) begin
      fails++;
      $display("FAIL health_sticky: got %0d bad cycles, required 0", bad);
    end
  endtask

  task automatic test_health_boundary();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    vec++;
    if (err_o !== 1'b0) begin
      fails++;
      $display("FAIL health_clear: got err=%b, required 0", err_o);
    end
    en_i = 1'b1;
    for (int i = 0; i < 15; i++) send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    vec++;
    if (err_o !== 1'b0 || we_o !== 4'b0010 || wdata_o !== 32'hFEFEFEFE) begin
      fails++;
      $display("FAIL health_15: got err=%b we=%b wdata=%h, required 0 0010 fefefefe", err_o, we_o, wdata_o);
    end
  endtask

  initial begin
    test_reset();
    test_byte_order();
    test_backpressure();
    test_gaps();
    test_abort();
    test_reset_states();
    test_health();
    test_health_boundary();
    $display("== %0d vectors applied, %0d miscompares ==", vec, fails);
    $finish;
  end

endmodule
